// File: rtl/mod_add_stream_pkg.sv
// Shared constants for the Kyber coefficient arithmetic units.
// The modular adder and the modular subtractor both import this package,
// so the modulus, the coefficient width and the polynomial length stay consistent.
package mod_add_stream_pkg;

    localparam int KYBER_Q = 3329;  // Kyber prime modulus
    localparam int COEFF_W = 12;    // coefficient width, KYBER_Q < 2**COEFF_W
    localparam int N_COEFF = 256;   // coefficients per polynomial

endpackage : mod_add_stream_pkg

// File: rtl/mod_add_stream_if.sv
// Coefficient stream bundle: one input operand pair channel, one result channel.
//   in_valid / in_ready   : operand pair handshake
//   x_add, y_add          : operands
//   out_valid / out_ready : result handshake
//   z_add                 : result
//   out_last              : result closes a polynomial
// Modport slave is the adder side; modport master is the producer/consumer side.
interface mod_add_stream_if
    import mod_add_stream_pkg::*;
#(
    parameter int DATA_WIDTH = COEFF_W
);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] x_add;
    logic [DATA_WIDTH-1:0] y_add;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] z_add;
    logic                  out_last;

    modport slave (
        input  in_valid, x_add, y_add, out_ready,
        output in_ready, out_valid, z_add, out_last
    );

    modport master (
        output in_valid, x_add, y_add, out_ready,
        input  in_ready, out_valid, z_add, out_last
    );

endinterface : mod_add_stream_if

// File: rtl/mod_add_stream_core.sv
// Combinational datapath of the modular adder, split in two halves so the
// top level can put a register between them:
//   x, y       -> sum = x + y, red = sum - Q (two's complement, sign on top bit)
//   sel_sum,
//   sel_red    -> z = sel_red negative ? sel_sum : sel_red, truncated to DATA_WIDTH
// Only one conditional subtraction is made, so z < Q only when x + y < 2Q.
module mod_add_core #(
    parameter int DATA_WIDTH = 12,
    parameter int Q          = 3329
) (
    input  logic [DATA_WIDTH-1:0] x,
    input  logic [DATA_WIDTH-1:0] y,
    output logic [DATA_WIDTH:0]   sum,
    output logic [DATA_WIDTH+1:0] red,
    input  logic [DATA_WIDTH:0]   sel_sum,
    input  logic [DATA_WIDTH+1:0] sel_red,
    output logic [DATA_WIDTH-1:0] z
);

    localparam int RED_W = DATA_WIDTH + 2;

    assign sum = {1'b0, x} + {1'b0, y};
    assign red = {1'b0, sum} - RED_W'(Q);

    // A negative red means sum < Q, so the unreduced sum is already the result.
    assign z = DATA_WIDTH'(sel_red[RED_W-1] ? {1'b0, sel_sum} : sel_red);

endmodule : mod_add_core

// File: rtl/mod_add_stream.sv
// Streaming modular adder z = (x + y) mod Q, two-stage elastic pipeline.
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset, discards in-flight data
//   bus   : mod_add_stream_if.slave, operand and result handshakes
//   busy  : some pipeline stage holds valid data
// Stage 1 registers x+y and x+y-Q; stage 2 selects the reduced value.
// Both stages advance together whenever the output register is empty or
// being drained, which gives one coefficient per cycle with out_ready high.
module mod_add_stream
    import mod_add_stream_pkg::*;
#(
    parameter int DATA_WIDTH = COEFF_W,
    parameter int Q          = KYBER_Q,
    parameter int N_COEFF    = mod_add_stream_pkg::N_COEFF
) (
    input  logic              clk,
    input  logic              rst,
    mod_add_stream_if.slave   bus,
    output logic              busy
);

    localparam int                CNT_W   = (N_COEFF > 1) ? $clog2(N_COEFF) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(N_COEFF - 1);

    logic                  en;
    logic                  s1_valid;
    logic [DATA_WIDTH:0]   s1_sum;
    logic [DATA_WIDTH+1:0] s1_red;
    logic [DATA_WIDTH:0]   core_sum;
    logic [DATA_WIDTH+1:0] core_red;
    logic [DATA_WIDTH-1:0] core_z;
    logic [CNT_W-1:0]      cnt;

    // The whole pipeline moves as one; a stalled output freezes both stages.
    assign en           = ~rst & (~bus.out_valid | bus.out_ready);
    assign bus.in_ready = en;

    mod_add_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .Q          (Q)
    ) u_core (
        .x       (bus.x_add),
        .y       (bus.y_add),
        .sum     (core_sum),
        .red     (core_red),
        .sel_sum (s1_sum),
        .sel_red (s1_red),
        .z       (core_z)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.z_add     <= '0;
            cnt           <= '0;
        end else begin
            if (en) begin
                s1_valid      <= bus.in_valid;
                bus.out_valid <= s1_valid;
                if (s1_valid) begin
                    bus.z_add <= core_z;
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
            end
        end
    end

    // NOTE: stage-1 data registers carry no reset; s1_valid alone qualifies them,
    // and leaving them unreset keeps the reset net off the wide datapath.
    always_ff @(posedge clk) begin
        if (en && bus.in_valid) begin
            s1_sum <= core_sum;
            s1_red <= core_red;
        end
    end

    assign bus.out_last = bus.out_valid & (cnt == CNT_MAX);
    assign busy         = s1_valid | bus.out_valid;

endmodule : mod_add_stream
